ticket_pay_ctrl: RTL
====================

// Module: ticket_pay_ctrl
// PURPOSE
//   Payment and dispense controller downstream of dest_selector. On start it
//   latches the order (total price, ticket count), accumulates inserted coins,
//   then emits one ticket pulse per ticket and a one-cycle change report.
//   Cancel or coin timeout refunds everything paid. All state uses one clock.
// PARAMETERS
//   WIDTH    8   width of total, count, coin_value, paid, change
//   TIMEOUT  30  cycles in PAY with no coin before auto-refund (>=1)
// PORTS
//   clk           in   1      clock, rising edge
//   rst           in   1      synchronous reset, active-high
//   start         in   1      latch order from total/count (honoured in IDLE only)
//   total         in   WIDTH  order price from dest_selector
//   count         in   WIDTH  number of tickets ordered
//   coin_valid    in   1      coin present this cycle
//   coin_value    in   WIDTH  value of the coin
//   cancel        in   1      user abort
//   busy          out  1      state != IDLE
//   paid          out  WIDTH  running amount paid (registered)
//   ticket_pulse  out  1      one-cycle pulse per dispensed ticket
//   change_valid  out  1      change holds a valid value this cycle
//   change        out  WIDTH  amount returned to user
//   done          out  1      with change_valid: sale completed
//   abort         out  1      with change_valid: cancelled or timed out
//   err           out  1      one-cycle: start rejected (total==0 or count==0)
//   coin_rej      out  1      one-cycle, cycle after a coin arrives outside PAY
// BEHAVIOUR
//   Reset (synchronous, active-high, wins over every input): state=IDLE and
//     every output 0. This includes paid, change, and all pulses.
//   Reset mid-sale discards the order and the paid amount; no pulses follow.
//   States: IDLE, PAY, DISP, CHG. State decodes (busy, ticket_pulse,
//     change_valid, done, abort) are combinational from registers only.
//   IDLE:
//     - start with total!=0 and count!=0: latch tot_r/cnt_r, set paid=0,
//       clear the timer, go to PAY on the next edge.
//     - start with total==0 or count==0: err=1 for the next cycle; stay IDLE.
//   PAY, checked in this order at each edge:
//     - A coin is always added first. paid_nxt = paid + coin_value, saturating
//       at 2^WIDTH-1. Each coin clears the timer.
//     - cancel, or the timer reaching TIMEOUT with no coin: go to CHG with
//       change = paid_nxt, abort. A coin arriving with cancel is refunded.
//     - otherwise, if paid_nxt >= tot_r: go to DISP with
//       change = paid_nxt - tot_r, done.
//     - otherwise stay in PAY. The timer increments on every coin-less cycle.
//   DISP:
//     - ticket_pulse=1 in DISP cycles 0, 2, 4, ..., 2*(cnt_r-1).
//     - After the last pulse, the next edge enters CHG. DISP lasts 2*cnt_r-1
//       cycles.
//     - cancel, start and coins are ignored here; coins raise coin_rej.
//   CHG: exactly one cycle.
//     - change_valid=1, with done or abort set (never both); change may be 0.
//     - The next edge enters IDLE. paid holds its value until the next start.
//   A start in the same cycle as CHG is ignored; the order is re-issued in IDLE.
//   Coin-to-paid latency is 1 cycle. The first ticket_pulse is in the cycle
//     after the coin edge that completes payment.
// TESTING
//   1 total=50,count=5, coins 20,20,20 -> paid 20,40,60; 5 ticket_pulse
//     spaced 2 cycles; change_valid,done,change=10; then busy=0.
//   2 total=34,count=2, coins 30,4 (exact) -> 2 pulses; change=0, done=1.
//   3 total=50,count=1, coin 20 then cancel -> no ticket_pulse; change=20,
//     abort=1; coin together with cancel -> that coin included in change.
//   4 TIMEOUT=4, total=10, coin 5 then idle -> CHG exactly 4 coin-less cycles
//     after the coin; change=5, abort=1.
//   5 total=250,count=1, coins 200,200 -> paid saturates 255; change=5.
//     start with count=0 -> err pulse, busy=0.
//   6 rst asserted in DISP after 2 pulses -> all outputs 0 next cycle, no more
//     pulses. Coin in IDLE -> coin_rej one cycle later, paid unchanged.

Source files
------------

// File: rtl/ticket_pay_ctrl.sv
// rtl/ticket_pay_ctrl.sv - order latch, coin accumulation, ticket dispense and change report
`timescale 1ns/1ps
module ticket_pay_ctrl #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 30
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] total,
  input  logic [WIDTH-1:0] count,
  input  logic             coin_valid,
  input  logic [WIDTH-1:0] coin_value,
  input  logic             cancel,
  output logic             busy,
  output logic [WIDTH-1:0] paid,
  output logic             ticket_pulse,
  output logic             change_valid,
  output logic [WIDTH-1:0] change,
  output logic             done,
  output logic             abort,
  output logic             err,
  output logic             coin_rej
);

  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, PAY, DISP, CHG} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] tot_r, tot_nxt;
  logic [WIDTH-1:0] left_r, left_nxt;
  logic             phase_r, phase_nxt;
  logic [WIDTH-1:0] paid_r, paid_nxt;
  logic [TW-1:0]    timer_r, timer_nxt;
  logic [WIDTH-1:0] change_r, change_nxt;
  logic             abort_r, abort_nxt;
  logic             err_r, err_nxt;
  logic             coin_rej_r, coin_rej_nxt;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] paid_add;
  logic [TW-1:0]    timer_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tot_r      <= '0;
      left_r     <= '0;
      phase_r    <= 1'b0;
      paid_r     <= '0;
      timer_r    <= '0;
      change_r   <= '0;
      abort_r    <= 1'b0;
      err_r      <= 1'b0;
      coin_rej_r <= 1'b0;
    end else begin
      state      <= state_nxt;
      tot_r      <= tot_nxt;
      left_r     <= left_nxt;
      phase_r    <= phase_nxt;
      paid_r     <= paid_nxt;
      timer_r    <= timer_nxt;
      change_r   <= change_nxt;
      abort_r    <= abort_nxt;
      err_r      <= err_nxt;
      coin_rej_r <= coin_rej_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    tot_nxt      = tot_r;
    left_nxt     = left_r;
    phase_nxt    = phase_r;
    paid_nxt     = paid_r;
    timer_nxt    = timer_r;
    change_nxt   = change_r;
    abort_nxt    = abort_r;
    err_nxt      = 1'b0;
    coin_rej_nxt = coin_valid && (state != PAY);

    // Saturating add so an overpaying coin never wraps the running total
    sum       = {1'b0, paid_r} + {1'b0, coin_value};
    paid_add  = coin_valid ? (sum[WIDTH] ? '1 : sum[WIDTH-1:0]) : paid_r;
    timer_inc = timer_r + TW'(1);

    case (state)
      IDLE: begin
        if (start) begin
          if (total != '0 && count != '0) begin
            tot_nxt   = total;
            left_nxt  = count;
            phase_nxt = 1'b0;
            paid_nxt  = '0;
            timer_nxt = '0;
            state_nxt = PAY;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      PAY: begin
        paid_nxt  = paid_add;
        timer_nxt = coin_valid ? '0 : timer_inc;
        if (cancel || (!coin_valid && timer_inc == TW'(TIMEOUT))) begin
          change_nxt = paid_add;
          abort_nxt  = 1'b1;
          state_nxt  = CHG;
        end else if (paid_add >= tot_r) begin
          change_nxt = paid_add - tot_r;
          abort_nxt  = 1'b0;
          phase_nxt  = 1'b0;
          state_nxt  = DISP;
        end
      end
      DISP: begin
        // phase 0 is a pulse cycle, phase 1 the gap between pulses
        if (!phase_r) begin
          if (left_r == WIDTH'(1)) begin
            state_nxt = CHG;
          end else begin
            left_nxt  = left_r - WIDTH'(1);
            phase_nxt = 1'b1;
          end
        end else begin
          phase_nxt = 1'b0;
        end
      end
      CHG: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy         = (state != IDLE);
  assign paid         = paid_r;
  assign ticket_pulse = (state == DISP) && !phase_r;
  assign change_valid = (state == CHG);
  assign change       = change_r;
  assign done         = (state == CHG) && !abort_r;
  assign abort        = (state == CHG) && abort_r;
  assign err          = err_r;
  assign coin_rej     = coin_rej_r;

endmodule
